// File: rtl/bridge_target_sequencer.sv
// bridge_target_sequencer
//   Sequences PMP bus commands from the host bridge onto up to NUM_TARGETS
//   core-side targets. Each command is decoded by pmp_addr[31:28], issued as a
//   held level request to the selected target, and completed by that target's
//   one-cycle ack. Read data returns on a registered pmp_rd_data. A one-deep
//   pending slot absorbs a command that arrives while a transfer is in flight.
//   Stalled targets are aborted by a timeout. Errors are kept in sticky flags.
//
// Optional feature macro: BRIDGE_SEQ_STATS_EN
//   When defined, region 0xF is internal and holds three saturating counters:
//   completed reads (0xF000_0000), completed writes (0xF000_0004) and
//   timeouts (0xF000_0008). A write to 0xF000_000C clears all three.
//   In this build NUM_TARGETS must be <= 15.
//
// Ports:
//   clk, reset_n        bridge clock, synchronous active-low reset
//   pmp_addr/_valid     word address and its qualifier
//   pmp_rd, pmp_wr      one-cycle command strobes (both high = write)
//   pmp_wr_data         write data
//   pmp_rd_data         registered read-return word
//   tgt_sel             one-hot target select
//   tgt_addr            pmp_addr[27:0] of the active command
//   tgt_rd, tgt_wr      level requests, held until ack or timeout
//   tgt_wr_data         write data of the active command
//   tgt_rd_data         per-target read data, target i at [32i+31:32i]
//   tgt_ack             per-target one-cycle completion
//   busy                transfer in flight or pending slot occupied
//   err_timeout         sticky: a target failed to ack in time
//   err_overflow        sticky: a command was dropped, pending slot full
//   clr_status          clears both sticky flags (a same-cycle set wins)
module bridge_target_sequencer #(
  parameter int unsigned NUM_TARGETS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] UNMAPPED_DATA  = 32'hFFFF_FFFF,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [31:0]               pmp_addr,
  input  logic                      pmp_addr_valid,
  input  logic                      pmp_rd,
  input  logic                      pmp_wr,
  input  logic [31:0]               pmp_wr_data,
  output logic [31:0]               pmp_rd_data,
  output logic [NUM_TARGETS-1:0]    tgt_sel,
  output logic [27:0]               tgt_addr,
  output logic                      tgt_rd,
  output logic                      tgt_wr,
  output logic [31:0]               tgt_wr_data,
  input  logic [NUM_TARGETS*32-1:0] tgt_rd_data,
  input  logic [NUM_TARGETS-1:0]    tgt_ack,
  output logic                      busy,
  output logic                      err_timeout,
  output logic                      err_overflow,
  input  logic                      clr_status
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     pend_vld_q, pend_vld_d;
  logic [31:0]              pend_addr_q, pend_addr_d;
  logic [31:0]              pend_data_q, pend_data_d;
  logic                     pend_wr_q, pend_wr_d;
  logic [31:0]              pmp_rd_data_q, pmp_rd_data_d;
  logic [NUM_TARGETS-1:0]   tgt_sel_q, tgt_sel_d;
  logic [27:0]              tgt_addr_q, tgt_addr_d;
  logic                     tgt_rd_q, tgt_rd_d;
  logic                     tgt_wr_q, tgt_wr_d;
  logic [31:0]              tgt_wr_data_q, tgt_wr_data_d;
  logic                     busy_q, busy_d;
  logic                     err_timeout_q, err_timeout_d;
  logic                     err_overflow_q, err_overflow_d;

  logic                     cmd_vld;
  logic                     sel_vld;
  logic [31:0]              sel_addr;
  logic [31:0]              sel_data;
  logic                     sel_wr;
  logic                     ack_hit;
  logic [31:0]              ack_data;
  logic                     to_ev;
  logic                     of_ev;

`ifdef BRIDGE_SEQ_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_to_q, stat_to_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  assign cmd_vld = pmp_addr_valid & (pmp_rd | pmp_wr);

  // Only the selected target's ack and data matter; others are masked off.
  assign ack_hit = |(tgt_ack & tgt_sel_q);

  always_comb begin
    ack_data = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (tgt_sel_q[i]) ack_data = tgt_rd_data[32*i +: 32];
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_vld_d     = pend_vld_q;
    pend_addr_d    = pend_addr_q;
    pend_data_d    = pend_data_q;
    pend_wr_d      = pend_wr_q;
    pmp_rd_data_d  = pmp_rd_data_q;
    tgt_sel_d      = tgt_sel_q;
    tgt_addr_d     = tgt_addr_q;
    tgt_rd_d       = tgt_rd_q;
    tgt_wr_d       = tgt_wr_q;
    tgt_wr_data_d  = tgt_wr_data_q;
    sel_vld        = 1'b0;
    sel_addr       = pend_addr_q;
    sel_data       = pend_data_q;
    sel_wr         = pend_wr_q;
    to_ev          = 1'b0;
    of_ev          = 1'b0;
`ifdef BRIDGE_SEQ_STATS_EN
    stat_rd_d      = stat_rd_q;
    stat_wr_d      = stat_wr_q;
    stat_to_d      = stat_to_q;
`endif

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          // Pending drains first; a command arriving now takes the freed slot.
          sel_vld    = 1'b1;
          pend_vld_d = cmd_vld;
          if (cmd_vld) begin
            pend_addr_d = pmp_addr;
            pend_data_d = pmp_wr_data;
            pend_wr_d   = pmp_wr;
          end
        end else if (cmd_vld) begin
          sel_vld  = 1'b1;
          sel_addr = pmp_addr;
          sel_data = pmp_wr_data;
          sel_wr   = pmp_wr;
        end

        if (sel_vld) begin
          if (32'(sel_addr[31:28]) < NUM_TARGETS) begin
            state_d       = ISSUE;
            tgt_sel_d     = NUM_TARGETS'(1) << sel_addr[31:28];
            tgt_addr_d    = sel_addr[27:0];
            tgt_wr_data_d = sel_data;
            tgt_rd_d      = ~sel_wr;
            tgt_wr_d      = sel_wr;
          end
`ifdef BRIDGE_SEQ_STATS_EN
          else if (sel_addr[31:28] == 4'hF) begin
            if (sel_wr) begin
              if (sel_addr == 32'hF000_000C) begin
                stat_rd_d = '0;
                stat_wr_d = '0;
                stat_to_d = '0;
              end
            end else begin
              case (sel_addr)
                32'hF000_0000: pmp_rd_data_d = stat_rd_q;
                32'hF000_0004: pmp_rd_data_d = stat_wr_q;
                32'hF000_0008: pmp_rd_data_d = stat_to_q;
                default:       pmp_rd_data_d = UNMAPPED_DATA;
              endcase
            end
          end
`endif
          else if (!sel_wr) begin
            // Unmapped read answers immediately; unmapped write is discarded.
            pmp_rd_data_d = UNMAPPED_DATA;
          end
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (ack_hit) begin
          tgt_rd_d  = 1'b0;
          tgt_wr_d  = 1'b0;
          tgt_sel_d = '0;
          state_d   = IDLE;
          if (tgt_rd_q) pmp_rd_data_d = ack_data;
`ifdef BRIDGE_SEQ_STATS_EN
          if (tgt_rd_q) stat_rd_d = sat_inc(stat_rd_q);
          else          stat_wr_d = sat_inc(stat_wr_q);
`endif
        end else if (cnt_q == CNT_LAST) begin
          tgt_rd_d  = 1'b0;
          tgt_wr_d  = 1'b0;
          tgt_sel_d = '0;
          state_d   = IDLE;
          to_ev     = 1'b1;
          if (tgt_rd_q) pmp_rd_data_d = TIMEOUT_DATA;
`ifdef BRIDGE_SEQ_STATS_EN
          stat_to_d = sat_inc(stat_to_q);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Commands arriving mid-transfer park in the single pending slot.
    if (state_q != IDLE && cmd_vld) begin
      if (pend_vld_q) begin
        of_ev = 1'b1;
      end else begin
        pend_vld_d  = 1'b1;
        pend_addr_d = pmp_addr;
        pend_data_d = pmp_wr_data;
        pend_wr_d   = pmp_wr;
      end
    end

    err_timeout_d  = to_ev | (err_timeout_q & ~clr_status);
    err_overflow_d = of_ev | (err_overflow_q & ~clr_status);
    busy_d         = (state_d != IDLE) | pend_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pend_vld_q     <= 1'b0;
      pmp_rd_data_q  <= 32'h0;
      tgt_sel_q      <= '0;
      tgt_addr_q     <= '0;
      tgt_rd_q       <= 1'b0;
      tgt_wr_q       <= 1'b0;
      tgt_wr_data_q  <= '0;
      busy_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
`ifdef BRIDGE_SEQ_STATS_EN
      stat_rd_q      <= '0;
      stat_wr_q      <= '0;
      stat_to_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_vld_q     <= pend_vld_d;
      pmp_rd_data_q  <= pmp_rd_data_d;
      tgt_sel_q      <= tgt_sel_d;
      tgt_addr_q     <= tgt_addr_d;
      tgt_rd_q       <= tgt_rd_d;
      tgt_wr_q       <= tgt_wr_d;
      tgt_wr_data_q  <= tgt_wr_data_d;
      busy_q         <= busy_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
`ifdef BRIDGE_SEQ_STATS_EN
      stat_rd_q      <= stat_rd_d;
      stat_wr_q      <= stat_wr_d;
      stat_to_q      <= stat_to_d;
`endif
    end
    // Pending payload is qualified by pend_vld_q and needs no reset.
    pend_addr_q <= pend_addr_d;
    pend_data_q <= pend_data_d;
    pend_wr_q   <= pend_wr_d;
  end

  assign pmp_rd_data  = pmp_rd_data_q;
  assign tgt_sel      = tgt_sel_q;
  assign tgt_addr     = tgt_addr_q;
  assign tgt_rd       = tgt_rd_q;
  assign tgt_wr       = tgt_wr_q;
  assign tgt_wr_data  = tgt_wr_data_q;
  assign busy         = busy_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;

endmodule
